// File: rtl/divmod_seq_if.sv
// rtl/divmod_seq_if.sv - start/busy/done handshake bundle for the sequential divide/modulo unit
//
// Signals (master = requester, slave = divmod_seq):
//   start        m->s  request, sampled only when the unit is idle
//   a, b         m->s  dividend / divisor, captured on an accepted start
//   signed_mode  m->s  1 = two's-complement operands
//   sel_rem      m->s  1 = c carries remainder, 0 = c carries quotient
//   busy         s->m  operation in progress
//   done         s->m  one-cycle pulse, results valid
//   q, r, c      s->m  quotient, remainder, selected result
//   banderas     s->m  {N, Z, C, V}
interface divmod_seq_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         signed_mode;
    logic         sel_rem;
    logic         busy;
    logic         done;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic [N-1:0] c;
    logic [3:0]   banderas;

    modport master (
        output start, a, b, signed_mode, sel_rem,
        input  busy, done, q, r, c, banderas
    );

    modport slave (
        input  start, a, b, signed_mode, sel_rem,
        output busy, done, q, r, c, banderas
    );
endinterface

// File: rtl/divmod_seq.sv
// rtl/divmod_seq.sv - radix-2 restoring divider, one quotient bit per cycle, signed/unsigned
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  divmod_seq_if slave modport (start/a/b/mode in, busy/done/q/r/c/banderas out)
module divmod_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    divmod_seq_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  rem_q;
    logic [N-1:0]  quo_q;
    logic [N-1:0]  dvs_q;
    logic [N-1:0]  a_q;
    logic          sm_q;
    logic          sel_q;
    logic          qneg_q;
    logic          rneg_q;
    logic          dz_q;
    logic          ovf_q;
    logic          busy_q;
    logic          done_q;
    logic [N-1:0]  q_q;
    logic [N-1:0]  r_q;
    logic [N-1:0]  c_q;
    logic [3:0]    flags_q;

    logic [N-1:0]  abs_a;
    logic [N-1:0]  abs_b;
    logic          is_dz;
    logic          is_ovf;
    logic [N:0]    shifted;
    logic [N:0]    diff;
    logic          fits;
    logic [N-1:0]  rem_d;
    logic [N-1:0]  quo_d;
    logic [N-1:0]  q_fin;
    logic [N-1:0]  r_fin;
    logic [N-1:0]  c_fin;
    logic [3:0]    flags_fin;

    always_comb begin
        abs_a = (bus.signed_mode && bus.a[N-1]) ? -bus.a : bus.a;
        abs_b = (bus.signed_mode && bus.b[N-1]) ? -bus.b : bus.b;
        is_dz  = (bus.b == '0);
        // Most-negative / -1 has no representable quotient.
        is_ovf = bus.signed_mode && (bus.a == {1'b1, {(N-1){1'b0}}}) && (bus.b == '1);

        // The partial remainder is shifted left with the next dividend bit
        // pulled from the top of quo_q; the extra bit keeps the compare exact
        // when |b| uses the full unsigned width.
        shifted = {rem_q, quo_q[N-1]};
        diff    = shifted - {1'b0, dvs_q};
        fits    = (shifted >= {1'b0, dvs_q});
        rem_d   = fits ? diff[N-1:0] : shifted[N-1:0];
        quo_d   = {quo_q[N-2:0], fits};

        if (dz_q) begin
            q_fin = '1;
            r_fin = a_q;
        end else if (ovf_q) begin
            q_fin = a_q;
            r_fin = '0;
        end else begin
            q_fin = qneg_q ? -quo_q : quo_q;
            r_fin = rneg_q ? -rem_q : rem_q;
        end
        c_fin     = sel_q ? r_fin : q_fin;
        flags_fin = {sm_q & c_fin[N-1], (c_fin == '0), 1'b0, dz_q | ovf_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            a_q     <= '0;
            sm_q    <= 1'b0;
            sel_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            flags_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    // A start that coincides with the done pulse is dropped;
                    // the requester must re-issue it in a clean idle cycle.
                    if (bus.start && !done_q) begin
                        a_q     <= bus.a;
                        sm_q    <= bus.signed_mode;
                        sel_q   <= bus.sel_rem;
                        qneg_q  <= bus.signed_mode & (bus.a[N-1] ^ bus.b[N-1]);
                        rneg_q  <= bus.signed_mode & bus.a[N-1];
                        dz_q    <= is_dz;
                        ovf_q   <= is_ovf;
                        rem_q   <= '0;
                        quo_q   <= abs_a;
                        dvs_q   <= abs_b;
                        cnt_q   <= CW'(N);
                        busy_q  <= 1'b1;
                        state_q <= (is_dz || is_ovf) ? S_FIN : S_CALC;
                    end
                end
                S_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    q_q     <= q_fin;
                    r_q     <= r_fin;
                    c_q     <= c_fin;
                    flags_q <= flags_fin;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.q        = q_q;
    assign bus.r        = r_q;
    assign bus.c        = c_q;
    assign bus.banderas = flags_q;
endmodule

// File: tb/tb_divmod_seq.sv
// tb/tb_divmod_seq.sv - self-checking bench for divmod_seq
module tb_divmod_seq;
    localparam int N = 32;

    logic clk;
    logic rst;

    divmod_seq_if #(.N(N)) dif ();

    divmod_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] pend_q, pend_r, pend_c;
    logic [3:0]  pend_f;
    logic        pend_valid = 1'b0;
    logic [31:0] held_q = '0, held_r = '0, held_c = '0;
    logic [3:0]  held_f = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic sm, input logic sel,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic [31:0] c, output logic [3:0] f);
        logic   v;
        longint sa, sb;
        v = 1'b0;
        if (b == 32'd0) begin
            q = '1; r = a; v = 1'b1;
        end else if (sm && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0; v = 1'b1;
        end else if (sm) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        c = sel ? r : q;
        f = {sm & c[31], (c == 32'd0), 1'b0, v};
    endfunction

    // Per-cycle compare: on done the outputs must match the pending model
    // result; on every other non-reset cycle they must hold the last result.
    always @(negedge clk) begin
        if (!rst) begin
            if (dif.done) begin
                if (!pend_valid) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected done=0");
                end else begin
                    chk("done_q", dif.q, pend_q);
                    chk("done_r", dif.r, pend_r);
                    chk("done_c", dif.c, pend_c);
                    chk("done_flags", {28'd0, dif.banderas}, {28'd0, pend_f});
                    held_q = pend_q; held_r = pend_r; held_c = pend_c; held_f = pend_f;
                    pend_valid = 1'b0;
                end
            end else begin
                chk("hold_q", dif.q, held_q);
                chk("hold_r", dif.r, held_r);
                chk("hold_c", dif.c, held_c);
                chk("hold_flags", {28'd0, dif.banderas}, {28'd0, held_f});
            end
        end
    end

    task automatic begin_op(input logic [31:0] a, input logic [31:0] b,
                            input logic sm, input logic sel);
        @(posedge clk); #1;
        dif.a = a; dif.b = b; dif.signed_mode = sm; dif.sel_rem = sel;
        dif.start = 1'b1;
        model(a, b, sm, sel, pend_q, pend_r, pend_c, pend_f);
        pend_valid = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        // Scramble inputs to show they were captured.
        dif.a = ~a; dif.b = ~b; dif.signed_mode = ~sm; dif.sel_rem = ~sel;
        chk("busy_after_start", {31'd0, dif.busy}, 32'd1);
    endtask

    task automatic wait_done(input int start_cyc, input int exp_lat);
        int cyc;
        cyc = start_cyc;
        while (!dif.done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("busy_at_done", {31'd0, dif.busy}, 32'd0);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic sm, input logic sel, input int exp_lat);
        begin_op(a, b, sm, sel);
        wait_done(0, exp_lat);
    endtask

    logic [31:0] mq, mr, mc;
    logic [3:0]  mf;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        dif.start = 1'b0; dif.a = '0; dif.b = '0; dif.signed_mode = 1'b0; dif.sel_rem = 1'b0;

        // Pin the model against hand-computed values.
        model(32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 1'b0, mq, mr, mc, mf);
        chk("model_m8_m3_q", mq, 32'd2);
        chk("model_m8_m3_r", mr, 32'hFFFF_FFFE);
        model(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, mq, mr, mc, mf);
        chk("model_7_m2_q", mq, 32'hFFFF_FFFD);
        chk("model_7_m2_c", mc, 32'd1);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, dif.busy}, 32'd0);
        chk("rst_done", {31'd0, dif.done}, 32'd0);
        chk("rst_q", dif.q, 32'd0);
        chk("rst_c", dif.c, 32'd0);
        chk("rst_flags", {28'd0, dif.banderas}, 32'd0);
        rst = 1'b0;

        do_op(32'd100, 32'd7, 1'b0, 1'b0, N + 1);
        chk("u100_7_q", dif.q, 32'd14);
        chk("u100_7_r", dif.r, 32'd2);
        chk("u100_7_c", dif.c, 32'd14);
        chk("u100_7_f", {28'd0, dif.banderas}, 32'b0000);

        do_op(32'd100, 32'd7, 1'b0, 1'b1, N + 1);
        chk("u100_7_rem_c", dif.c, 32'd2);

        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, N + 1);
        chk("s_m7_2_q", dif.q, 32'hFFFF_FFFD);
        chk("s_m7_2_r", dif.r, 32'hFFFF_FFFF);
        chk("s_m7_2_f", {28'd0, dif.banderas}, 32'b1000);

        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, N + 1);
        chk("s_m7_2_rem_c", dif.c, 32'hFFFF_FFFF);
        chk("s_m7_2_rem_f", {28'd0, dif.banderas}, 32'b1000);

        do_op(32'd21, 32'd7, 1'b0, 1'b1, N + 1);
        chk("u21_7_r", dif.r, 32'd0);
        chk("u21_7_f", {28'd0, dif.banderas}, 32'b0100);

        do_op(32'h8000_0000, 32'd3, 1'b0, 1'b0, N + 1);
        chk("u_min_3_q", dif.q, 32'h2AAA_AAAA);
        chk("u_min_3_n", {31'd0, dif.banderas[3]}, 32'd0);

        do_op(32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 1'b1, N + 1);
        do_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b0, N + 1);
        chk("u_big_q", dif.q, 32'd1);

        do_op(32'h1234, 32'd0, 1'b1, 1'b0, 1);
        chk("dz_s_q", dif.q, 32'hFFFF_FFFF);
        chk("dz_s_r", dif.r, 32'h1234);
        chk("dz_s_f", {28'd0, dif.banderas}, 32'b1001);

        do_op(32'h1234, 32'd0, 1'b0, 1'b0, 1);
        chk("dz_u_f", {28'd0, dif.banderas}, 32'b0001);

        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
        chk("ovf_q", dif.q, 32'h8000_0000);
        chk("ovf_r", dif.r, 32'd0);
        chk("ovf_v", {31'd0, dif.banderas[0]}, 32'd1);

        // Start during the done cycle must be dropped.
        dif.a = 32'd5; dif.b = 32'd1; dif.signed_mode = 1'b0; dif.sel_rem = 1'b0;
        dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        chk("start_in_done_busy", {31'd0, dif.busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("start_in_done_idle", {31'd0, dif.busy}, 32'd0);

        // Start mid-operation is ignored.
        begin_op(32'd100, 32'd7, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        dif.a = 32'd9; dif.b = 32'd4; dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        wait_done(5, N + 1);
        chk("ignored_start_q", dif.q, 32'd14);
        chk("ignored_start_r", dif.r, 32'd2);

        // Reset mid-CALC aborts with no done pulse.
        begin_op(32'd1000, 32'd3, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        pend_valid = 1'b0;
        held_q = '0; held_r = '0; held_c = '0; held_f = '0;
        #1;
        chk("abort_busy", {31'd0, dif.busy}, 32'd0);
        chk("abort_q", dif.q, 32'd0);
        chk("abort_r", dif.r, 32'd0);
        chk("abort_c", dif.c, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        do_op(32'd9, 32'd4, 1'b0, 1'b0, N + 1);
        chk("after_rst_q", dif.q, 32'd2);
        chk("after_rst_r", dif.r, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/divmod_seq.md
Name: divmod_seq

Overview:
Multi-cycle integer divide/modulo unit for the CPU execute stage. It is the parametrised successor of the single-cycle combinational modulo unit. It adds a quotient output, signed/unsigned modes, divide-by-zero and overflow handling, and a start/busy/done handshake, so a full-width divider stays off the critical path. It uses a radix-2 restoring algorithm that resolves one quotient bit per cycle. Flags use the ALU-wide banderas ordering.

Parameters:
N, 32, operand and result width in bits (minimum 4).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
a  in  N  dividend; captured on accepted start
b  in  N  divisor; captured on accepted start
signed_mode  in  1  1 = two's-complement operands; captured on start
sel_rem  in  1  1 = c carries remainder, 0 = c carries quotient; captured on start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  single-cycle pulse; q, r, c and banderas are valid
q  out  N  quotient
r  out  N  remainder
c  out  N  selected result (r if sel_rem, else q)
banderas  out  4  [3] N negative, [2] Z zero, [1] C carry, [0] V overflow/invalid

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE. busy=0, done=0, q=r=c=0, banderas=0000, iteration counter=0.
- States:
  - IDLE: start=1 latches operands and mode bits, computes absolute values when signed, and sets counter=N.
    - If b==0, go to FIN.
    - Else if signed_mode, a==100…0 and b==all ones, go to FIN.
    - Otherwise go to CALC.
  - CALC: each cycle shifts the {rem,quo} pair left by 1 and subtracts |b| from rem. If the result is non-negative, keep it and set quo LSB=1; otherwise restore. Counter decrements. After exactly N CALC cycles, go to FIN.
  - FIN: applies sign correction, registers q/r/c/banderas, and pulses done=1 for one cycle. Returns to IDLE.
- Latency: start sampled at edge E0. For normal divides, CALC spans E1..EN and FIN registers at E(N+1), so done is high during cycle N+1. For the b==0 and overflow cases, done is high after E1 (cycle 1).
- Signed rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend: a == q*b + r and |r| < |b|.
- Divide by zero: q = all ones, r = a, V=1.
- Signed overflow (most negative / -1): q = a, r = 0, V=1.
- Flags (computed on c):
  - N = signed_mode & c[N-1]; always 0 in unsigned mode.
  - Z = (c == 0).
  - C = 0.
  - V as defined above, else 0.
- busy=1 in CALC and FIN; busy=0 in IDLE.
- start while busy is ignored; no queueing, and latched operands are unchanged.
- start in the same cycle as done: done is asserted from FIN, so the new start is not accepted until the next cycle in IDLE.
- Outputs q, r, c and banderas hold their last values after done until the next FIN or reset.
- Changes to a, b or mode inputs after an accepted start have no effect.
- Reset asserted mid-CALC aborts the operation with no done pulse. The first start after reset release behaves normally.

Test Plan:
- Unsigned, N=32: a=100, b=7, sel_rem=0 → done after N+1 cycles; q=14, r=2, c=14, banderas=0000. Same operands with sel_rem=1 → c=2.
- Signed: a=-7 (0xFFFFFFF9), b=2, sel_rem=0 → q=0xFFFFFFFD, r=0xFFFFFFFF, banderas=1000. Same with sel_rem=1 → c=0xFFFFFFFF, N=1.
- Zero remainder: a=21, b=7, sel_rem=1 → r=0, banderas=0100. Unsigned a=0x80000000, b=3, sel_rem=0 → q=0x2AAAAAAA, N=0.
- Divide by zero: a=0x1234, b=0, sel_rem=0 → done at cycle 1; q=0xFFFFFFFF, r=0x1234, banderas=1001 in signed mode, 0001 in unsigned mode.
- Signed overflow: a=0x80000000, b=0xFFFFFFFF, signed_mode=1 → done at cycle 1; q=0x80000000, r=0, V=1.
- Handshake and reset:
  - Pulse start with new operands at cycle 5 of a busy operation → ignored; the first result is unchanged.
  - Assert rst at cycle 10 → busy=0, q=r=c=0, and no done pulse.
  - After release, a=9, b=4 → q=2, r=1.
